// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common-data-bus arbiter with per-source result FIFOs
// Buffers functional-unit results and broadcasts one {tag,data} per cycle (round-robin or fixed priority).
module cdb_arbiter #(
  parameter int NUM_SRC   = 6,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4,
  parameter int BUF_DEPTH = 2,
  parameter int ARB_MODE  = 0,
  localparam int SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      cdb_hold,
  input  logic                      flush,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
);

  localparam int IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int PTR_W = $clog2(BUF_DEPTH) + 1;

  logic [TAG_W-1:0]  tag_mem  [NUM_SRC][BUF_DEPTH];
  logic [DATA_W-1:0] data_mem [NUM_SRC][BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr   [NUM_SRC];
  logic [PTR_W-1:0]  rd_ptr   [NUM_SRC];
  logic [NUM_SRC-1:0] empty, full, push, pop;
  logic [SRC_W-1:0]  rr_ptr, grant_idx;
  logic              grant_any, grant_valid;

  function automatic logic [IDX_W-1:0] slot(input logic [PTR_W-1:0] p);
    if (BUF_DEPTH == 1) return '0;
    else                return p[IDX_W-1:0];
  endfunction

  // Tag 0 completes the handshake but is never stored.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      empty[i]     = (wr_ptr[i] == rd_ptr[i]);
      full[i]      = ((wr_ptr[i] - rd_ptr[i]) == PTR_W'(BUF_DEPTH));
      src_ready[i] = reset & ~full[i] & ~flush;
      push[i]      = src_valid[i] & src_ready[i] & (src_tag[i*TAG_W +: TAG_W] != '0);
    end
  end

  always_comb begin
    int j;
    grant_any = 1'b0;
    grant_idx = '0;
    j         = 0;
    if (ARB_MODE == 0) begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        j = int'(rr_ptr) + k;
        if (j >= NUM_SRC) j = j - NUM_SRC;
        if (!grant_any && !empty[SRC_W'(j)]) begin
          grant_any = 1'b1;
          grant_idx = SRC_W'(j);
        end
      end
    end else begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (!empty[i]) begin
          grant_any = 1'b1;
          grant_idx = SRC_W'(i);
        end
      end
    end
  end

  assign grant_valid = grant_any & ~cdb_hold & ~flush;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i] = grant_valid && (grant_idx == SRC_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        tag_mem[i][slot(wr_ptr[i])]  <= src_tag[i*TAG_W +: TAG_W];
        data_mem[i][slot(wr_ptr[i])] <= src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Flush outranks push, pop and hold; cdb_tag/data/src keep their last broadcast when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr    <= SRC_W'(NUM_SRC - 1);
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr    <= SRC_W'(NUM_SRC - 1);
      cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
      end
      cdb_valid <= grant_valid;
      if (grant_valid) begin
        cdb_tag  <= tag_mem[grant_idx][slot(rd_ptr[grant_idx])];
        cdb_data <= data_mem[grant_idx][slot(rd_ptr[grant_idx])];
        cdb_src  <= grant_idx;
        if (ARB_MODE == 0) rr_ptr <= grant_idx;
      end
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset) (push & full) == '0);
  a_valid_tag_nonzero: assert property (@(posedge clk) disable iff (!reset) cdb_valid |-> (cdb_tag != '0));

endmodule
